// File: rtl/rr_arbiter8.sv
// ---------------------------------------------------------------------------
// rr_arbiter8 -- 8-way round-robin arbiter with registered, one-hot grant.
//
// A requester keeps the resource for as long as it holds its req bit. When
// it drops the bit, the priority pointer moves to the slot after it and a new
// winner is picked on the same edge, so there is no idle gap between owners.
//
// Optional feature (macro RR_ARBITER8_TIMEOUT_EN): a hold counter forces a
// hand-off to the next circular requester after HOLD_MAX consecutive grant
// cycles, but only while some other requester is waiting. Without the macro
// HOLD_MAX has no effect and a grant ends only on release or reset.
//
// Parameters
//   HOLD_MAX   maximum consecutive grant cycles before forced hand-off (2..256)
// Ports
//   clk        single clock, rising edge
//   rst_n      synchronous active-low reset
//   req[7:0]   request vector, bit i = requester i wants the resource
//   grant[7:0] one-hot grant, 8'h00 when nothing is granted
//   grant_idx  binary index of the current or most recent winner
//   grant_vld  1 while a grant is active
// ---------------------------------------------------------------------------
module rr_arbiter8 #(
  parameter int HOLD_MAX = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  output logic [7:0] grant,
  output logic [2:0] grant_idx,
  output logic       grant_vld
);

  // Range is enforced in every build so a bad override is caught early.
  if (HOLD_MAX < 2 || HOLD_MAX > 256) begin : g_bad_hold_max
    $error("rr_arbiter8: HOLD_MAX must be in 2..256");
  end

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t     state, state_nxt;
  logic [2:0] ptr, ptr_nxt;
  logic [2:0] idx_nxt;
  logic [3:0] pick;

`ifdef RR_ARBITER8_TIMEOUT_EN
  localparam int CW = $clog2(HOLD_MAX);
  localparam logic [CW-1:0] CNT_MAX = CW'(HOLD_MAX - 1);

  logic [CW-1:0] cnt, cnt_nxt;
  logic [7:0]    others;
`endif

  // Circular search starting at p. Returns {found, index}. Iterating from the
  // far end means the closest requester to p is the last one written.
  function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
    logic [3:0] res;
    logic [2:0] i;
    res = 4'b0;
    for (int k = 7; k >= 0; k--) begin
      i = p + 3'(k);
      if (r[i]) res = {1'b1, i};
    end
    return res;
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 3'd0;
      grant_idx <= 3'd0;
`ifdef RR_ARBITER8_TIMEOUT_EN
      cnt       <= '0;
`endif
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      grant_idx <= idx_nxt;
`ifdef RR_ARBITER8_TIMEOUT_EN
      cnt       <= cnt_nxt;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    idx_nxt   = grant_idx;
    pick      = 4'b0;
`ifdef RR_ARBITER8_TIMEOUT_EN
    cnt_nxt   = cnt;
    others    = req & ~(8'h01 << grant_idx);
`endif
    case (state)
      IDLE: begin
        pick = rr_pick(req, ptr);
        if (pick[3]) begin
          state_nxt = GRANT;
          idx_nxt   = pick[2:0];
`ifdef RR_ARBITER8_TIMEOUT_EN
          cnt_nxt   = '0;
`endif
        end
      end
      GRANT: begin
        // A release takes precedence over an expiring hold counter.
        if (!req[grant_idx]) begin
          ptr_nxt = grant_idx + 3'd1;
          pick    = rr_pick(req, ptr_nxt);
          if (pick[3]) begin
            idx_nxt = pick[2:0];
`ifdef RR_ARBITER8_TIMEOUT_EN
            cnt_nxt = '0;
`endif
          end else begin
            state_nxt = IDLE;
          end
        end
`ifdef RR_ARBITER8_TIMEOUT_EN
        else if (cnt == CNT_MAX) begin
          // Forced hand-off skips the owner; with nobody else waiting the
          // owner keeps the grant and the counter stays saturated.
          if (others != 8'h00) begin
            ptr_nxt = grant_idx + 3'd1;
            pick    = rr_pick(others, ptr_nxt);
            idx_nxt = pick[2:0];
            cnt_nxt = '0;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
`endif
      end
    endcase
  end

  // Outputs depend on registered state only, so req never reaches them
  // combinationally.
  always_comb begin
    grant_vld = (state == GRANT);
    grant     = grant_vld ? (8'h01 << grant_idx) : 8'h00;
  end

endmodule

// File: tb/tb_rr_arbiter8.sv
module tb_rr_arbiter8;

  localparam int HOLD = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req   = 8'h00;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       grant_vld;

  always #5 clk = ~clk;

  rr_arbiter8 #(.HOLD_MAX(HOLD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  typedef struct {
    logic       vld;
    logic [2:0] idx;
    logic [7:0] g;
  } exp_t;

  exp_t sb[$];

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state: who owns the resource and where the search starts.
  int m_act = 0;
  int m_ptr = 0;
  int m_idx = 0;
`ifdef RR_ARBITER8_TIMEOUT_EN
  int m_cnt = 0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // First requester found walking p, p+1, ... mod 8, skipping excl; -1 if none.
  function automatic int search(input logic [7:0] r, input int p, input int excl);
    for (int k = 0; k < 8; k++) begin
      int i;
      i = (p + k) % 8;
      if (r[i] && i != excl) return i;
    end
    return -1;
  endfunction

  // Advance the model by one clock edge with the given inputs, then queue
  // the outputs the DUT should show after that edge.
  task automatic model_step(input logic rn, input logic [7:0] r);
    int   w;
    exp_t e;
    if (!rn) begin
      m_act = 0; m_ptr = 0; m_idx = 0;
`ifdef RR_ARBITER8_TIMEOUT_EN
      m_cnt = 0;
`endif
    end else if (m_act == 0) begin
      w = search(r, m_ptr, -1);
      if (w >= 0) begin
        m_act = 1; m_idx = w;
`ifdef RR_ARBITER8_TIMEOUT_EN
        m_cnt = 0;
`endif
      end
    end else if (!r[m_idx]) begin
      m_ptr = (m_idx + 1) % 8;
      w = search(r, m_ptr, -1);
      if (w >= 0) begin
        m_idx = w;
`ifdef RR_ARBITER8_TIMEOUT_EN
        m_cnt = 0;
`endif
      end else begin
        m_act = 0;
      end
    end else begin
`ifdef RR_ARBITER8_TIMEOUT_EN
      w = search(r, (m_idx + 1) % 8, m_idx);
      if (m_cnt == HOLD - 1 && w >= 0) begin
        m_ptr = (m_idx + 1) % 8;
        m_idx = w;
        m_cnt = 0;
      end else if (m_cnt < HOLD - 1) begin
        m_cnt++;
      end
`endif
    end
    e.vld = (m_act != 0);
    e.idx = 3'(m_idx);
    e.g   = (m_act != 0) ? 8'(1 << m_idx) : 8'h00;
    sb.push_back(e);
  endtask

  // Called at a falling edge: drive inputs, predict, and move to the next
  // falling edge where the DUT shows the result of the edge in between.
  task automatic cyc(input logic rn, input logic [7:0] r);
    rst_n = rn;
    req   = r;
    model_step(rn, r);
    @(negedge clk);
  endtask

  task automatic dchk(input string name, input logic [7:0] g, input logic vld);
    chk({name, "_grant"}, grant, g);
    chk({name, "_vld"}, grant_vld, vld);
  endtask

  // Monitor: compares every DUT output sample against the queued prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("sb_vld", grant_vld, e.vld);
        chk("sb_idx", grant_idx, e.idx);
        chk("sb_grant", grant, e.g);
        chk("onehot", grant, grant_vld ? (8'h01 << grant_idx) : 8'h00);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [7:0] r;
    logic       rn;
    @(negedge clk);

    // Reset state
    repeat (3) cyc(1'b0, 8'h00);
    dchk("rst", 8'h00, 1'b0);
    chk("rst_idx", grant_idx, 3'd0);

    // 8'h81: requester 0 first, then 7 takes over with no gap
    cyc(1'b1, 8'h81);
    dchk("s1_first", 8'h01, 1'b1);
    chk("s1_idx", grant_idx, 3'd0);
    cyc(1'b1, 8'h80);
    dchk("s1_handover", 8'h80, 1'b1);
    cyc(1'b1, 8'h00);
    dchk("s1_idle", 8'h00, 1'b0);
    chk("s1_idx_hold", grant_idx, 3'd7);

    // 8'hFF, each owner releasing after one cycle: 0,1,...,7,0
    cyc(1'b0, 8'h00);
    cyc(1'b1, 8'hFF);
    dchk("s2_w0", 8'h01, 1'b1);
    for (int k = 0; k < 8; k++) begin
      cyc(1'b1, 8'hFF & ~(8'h01 << k));
      dchk("s2_rot", 8'h01 << ((k + 1) % 8), 1'b1);
    end
    cyc(1'b1, 8'h00);

    // Owner 7 releases with 8'h01 pending: pointer wraps to 0
    cyc(1'b0, 8'h00);
    cyc(1'b1, 8'h80);
    dchk("s3_own7", 8'h80, 1'b1);
    cyc(1'b1, 8'h01);
    dchk("s3_wrap", 8'h01, 1'b1);
    cyc(1'b1, 8'h00);

    // Reset during grant of requester 3
    cyc(1'b0, 8'h00);
    cyc(1'b1, 8'h08);
    dchk("s4_own3", 8'h08, 1'b1);
    cyc(1'b0, 8'h08);
    dchk("s4_rst", 8'h00, 1'b0);
    chk("s4_rst_idx", grant_idx, 3'd0);
    cyc(1'b1, 8'h08);
    dchk("s4_resume", 8'h08, 1'b1);

    // 8'h06 held
    cyc(1'b0, 8'h00);
`ifdef RR_ARBITER8_TIMEOUT_EN
    for (int t = 0; t < 16; t++) begin
      cyc(1'b1, 8'h06);
      dchk("s5_alt", ((t / 4) % 2 == 1) ? 8'h04 : 8'h02, 1'b1);
    end
    for (int t = 0; t < 20; t++) begin
      cyc(1'b1, 8'h02);
      dchk("s5_solo", 8'h02, 1'b1);
    end
`else
    for (int t = 0; t < 100; t++) begin
      cyc(1'b1, 8'h06);
      dchk("s6_hold", 8'h02, 1'b1);
    end
`endif

    // Random traffic with occasional resets; requests tend to persist so
    // grants last long enough to reach any hold limit.
    r = 8'h00;
    for (int n = 0; n < 3000; n++) begin
      rn = ($urandom_range(63) != 0);
      case ($urandom_range(3))
        0:       r = 8'($urandom);
        1:       r = r & 8'($urandom);
        default: r = (r == 8'h00) ? 8'($urandom) : r;
      endcase
      cyc(rn, r);
    end

    repeat (2) cyc(1'b1, 8'h00);
    @(negedge clk);
    chk("sb_drain", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rr_arbiter8.md
RR_ARBITER8 -- requirements
Module: rr_arbiter8

Interface
REQ-001 The module SHALL have parameter HOLD_MAX, default 16, meaning the maximum consecutive grant cycles before forced hand-off; it SHALL be legal for values 2..256 and SHALL be used only when RR_ARBITER8_TIMEOUT_EN is defined.
REQ-002 The module SHALL have port clk, input, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1 bit, a synchronous, active-low reset.
REQ-004 The module SHALL have port req, input, 8 bits, where req[i]=1 means requester i wants the shared resource.
REQ-005 The module SHALL have port grant, output, 8 bits, a one-hot grant that is all-zero when nothing is granted.
REQ-006 The module SHALL have port grant_idx, output, 3 bits, the binary index of the current or most recent winner.
REQ-007 The module SHALL have port grant_vld, output, 1 bit, which is 1 while a grant is active.

Function
REQ-008 The module SHALL implement a two-state FSM: IDLE (no grant) and GRANT (one requester owns the resource).
REQ-009 The module SHALL keep a registered 3-bit priority pointer ptr; arbitration picks the first i with req[i]=1, searching circularly ptr, ptr+1, ..., ptr+7, with the index wrapping mod 8.
REQ-010 In IDLE, at the edge where any req bit is 1, the FSM SHALL go to GRANT with the winner registered; grant is therefore visible one cycle after req is sampled, and this is the fixed latency.
REQ-011 In GRANT, the grant SHALL be held unchanged while req[grant_idx]=1, except as stated in REQ-015.
REQ-012 In GRANT, at the edge where req[grant_idx]=0 is sampled, the FSM SHALL set ptr=grant_idx+1 (mod 8) and re-arbitrate with that ptr in the same edge.
- If a winner exists, the FSM stays in GRANT with the new winner, with no idle gap.
- Otherwise it goes to IDLE.
REQ-013 The grant output SHALL always equal the one-hot decode of grant_idx (bit grant_idx set) when grant_vld=1, and SHALL be 8'h00 when grant_vld=0.
REQ-014 grant_idx SHALL hold its last winner value in IDLE; ptr SHALL change only on a release or on a forced hand-off.
REQ-015 Under RR_ARBITER8_TIMEOUT_EN, a hold counter SHALL clear on every new grant and increment on each cycle in GRANT.
- When the counter reaches HOLD_MAX-1 and any other req bit is 1, the next edge SHALL set ptr=grant_idx+1 and grant the next circular requester, excluding the current owner.
- If no other request exists, the grant continues and the counter saturates at HOLD_MAX-1.
REQ-016 If the current owner releases in the same cycle its timeout expires, the module SHALL treat the event as a normal release (REQ-012).
REQ-017 Request changes on bits other than grant_idx SHALL NOT affect an active grant before release or timeout.
REQ-018 The module SHALL be fully synchronous, with no combinational path from req to grant, grant_idx or grant_vld.

Reset
REQ-019 When rst_n=0 at a rising clk edge, the module SHALL set:
- FSM=IDLE, ptr=0, grant=8'h00, grant_idx=0, grant_vld=0, hold counter=0.
REQ-020 A reset asserted during GRANT SHALL drop the grant at that edge, regardless of req.
REQ-021 On the first edge with rst_n=1, normal arbitration SHALL resume with ptr=0, giving req[0] first priority.

Configuration
REQ-022 With macro RR_ARBITER8_TIMEOUT_EN defined, the hold counter and forced hand-off of REQ-015 SHALL be compiled in.
REQ-023 Without RR_ARBITER8_TIMEOUT_EN, the module SHALL contain no hold counter and SHALL ignore HOLD_MAX; a grant then ends only on release or reset.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Reset, then req=8'h81 held: grant=8'h01, grant_idx=0 one cycle later; req[0] drops -> next edge grant=8'h80, no grant_vld gap.
- req=8'hFF, each owner releasing after 1 cycle of grant: winners in order 0,1,...,7,0; each grant lasts 1 cycle.
- Owner 7 releases with req=8'h01 pending: ptr wraps to 0 and grant=8'h01 on the same edge.
- rst_n=0 during grant of requester 3: the next edge gives grant=0, grant_vld=0; after release of reset with req=8'h08 -> grant=8'h08.
- TIMEOUT_EN with HOLD_MAX=4 and req=8'h06 held: grant alternates 8'h02 -> 8'h04 every 4 cycles; with req=8'h02 only, grant stays 8'h02 indefinitely.
- Without TIMEOUT_EN and req=8'h06 held for 100 cycles: grant stays 8'h02 throughout.
- All scenarios: check grant==one-hot(grant_idx) when grant_vld=1, else grant==0.
